// File: rtl/cluster_cmd_responder.sv
// Responder end of the HPU command interface: one-entry issue register towards the backend
// engine plus an in-order command-ID FIFO that turns engine completions into response strobes.

package cluster_cmd_pkg;
    localparam int unsigned CMD_ID_W = 8;

    typedef struct packed {
        logic [CMD_ID_W-1:0] cmd_id;
        logic [3:0]          opcode;
        logic [31:0]         addr;
    } cmd_req_t;

    typedef struct packed {
        logic [CMD_ID_W-1:0] cmd_id;
        logic [1:0]          status;
    } cmd_resp_t;
endpackage

module cluster_cmd_responder #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter type cmd_req_t  = cluster_cmd_pkg::cmd_req_t,
    parameter type cmd_resp_t = cluster_cmd_pkg::cmd_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      cmd_valid_i,
    output logic      cmd_ready_o,
    input  cmd_req_t  cmd_i,
    output logic      cmd_resp_valid_o,
    output cmd_resp_t cmd_resp_o,
    output logic      eng_valid_o,
    input  logic      eng_ready_i,
    output cmd_req_t  eng_cmd_o,
    input  logic      eng_done_i,
    output logic      busy_o,
    output logic      err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned ID_W  = $bits(cmd_i.cmd_id);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ID_W-1:0]  id_mem_q [MAX_OUTSTANDING];
    logic             eng_valid_q, eng_valid_d;
    cmd_req_t         eng_cmd_q, eng_cmd_d;
    logic             resp_valid_q, resp_valid_d;
    cmd_resp_t        resp_q, resp_d;
    logic             err_q, err_d;

    logic accept;
    logic done_ok;

    // Ready never looks at eng_done_i: a slot freed by a completion is usable next cycle.
    assign cmd_ready_o = (!eng_valid_q || eng_ready_i) && (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign done_ok     = eng_done_i && (cnt_q != '0);

    always_comb begin
        cnt_d        = cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        eng_valid_d  = eng_valid_q;
        eng_cmd_d    = eng_cmd_q;
        resp_valid_d = 1'b0;
        resp_d       = resp_q;
        err_d        = err_q;

        case ({accept, done_ok})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (accept) begin
            eng_valid_d = 1'b1;
            eng_cmd_d   = cmd_i;
            wr_ptr_d    = (wr_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end else if (eng_ready_i) begin
            eng_valid_d = 1'b0;
        end

        if (done_ok) begin
            resp_valid_d  = 1'b1;
            resp_d        = '0;
            resp_d.cmd_id = id_mem_q[rd_ptr_q];
            rd_ptr_d      = (rd_ptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end

        if (eng_done_i && (cnt_q == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            eng_valid_q  <= 1'b0;
            eng_cmd_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            eng_valid_q  <= eng_valid_d;
            eng_cmd_q    <= eng_cmd_d;
            resp_valid_q <= resp_valid_d;
            resp_q       <= resp_d;
            err_q        <= err_d;
        end
    end

    // ID storage; ready guarantees a free slot whenever accept is high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
                id_mem_q[i] <= '0;
            end
        end else if (accept) begin
            id_mem_q[wr_ptr_q] <= cmd_i.cmd_id;
        end
    end

    assign eng_valid_o      = eng_valid_q;
    assign eng_cmd_o        = eng_cmd_q;
    assign cmd_resp_valid_o = resp_valid_q;
    assign cmd_resp_o       = resp_q;
    assign err_o            = err_q;
    assign busy_o           = (cnt_q != '0);

endmodule

// File: tb/tb_cluster_cmd_responder.sv
// Bench for cluster_cmd_responder: directed scenarios plus random traffic, all checked
// against a queue-based model of the command/response protocol.

module tb_cluster_cmd_responder;
    import cluster_cmd_pkg::*;

    localparam int MAX = 4;

    logic      clk_i = 1'b0;
    logic      rst_ni;
    logic      cmd_valid_i;
    logic      cmd_ready_o;
    cmd_req_t  cmd_i;
    logic      cmd_resp_valid_o;
    cmd_resp_t cmd_resp_o;
    logic      eng_valid_o;
    logic      eng_ready_i;
    cmd_req_t  eng_cmd_o;
    logic      eng_done_i;
    logic      busy_o;
    logic      err_o;

    int n_checks = 0;
    int n_fail   = 0;

    cluster_cmd_responder #(
        .MAX_OUTSTANDING(MAX),
        .cmd_req_t      (cmd_req_t),
        .cmd_resp_t     (cmd_resp_t)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .cmd_valid_i     (cmd_valid_i),
        .cmd_ready_o     (cmd_ready_o),
        .cmd_i           (cmd_i),
        .cmd_resp_valid_o(cmd_resp_valid_o),
        .cmd_resp_o      (cmd_resp_o),
        .eng_valid_o     (eng_valid_o),
        .eng_ready_i     (eng_ready_i),
        .eng_cmd_o       (eng_cmd_o),
        .eng_done_i      (eng_done_i),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: outstanding IDs in a queue, the issue slot as a held command.
    logic [7:0] m_q[$];
    bit         m_eng_valid;
    cmd_req_t   m_eng_cmd;
    bit         m_resp_valid;
    logic [7:0] m_resp_id;
    bit         m_err;

    function automatic bit exp_ready();
        return (!m_eng_valid || eng_ready_i) && (m_q.size() < MAX);
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        bit acc;
        bit dok;
        if (!rst_ni) begin
            m_q.delete();
            m_eng_valid  = 0;
            m_eng_cmd    = '0;
            m_resp_valid = 0;
            m_resp_id    = '0;
            m_err        = 0;
        end else begin
            acc = cmd_valid_i && exp_ready();
            dok = eng_done_i && (m_q.size() != 0);
            if (eng_done_i && m_q.size() == 0) m_err = 1;
            m_resp_valid = dok;
            if (dok) m_resp_id = m_q.pop_front();
            if (acc) begin
                m_q.push_back(cmd_i.cmd_id);
                m_eng_valid = 1;
                m_eng_cmd   = cmd_i;
            end else if (eng_ready_i) begin
                m_eng_valid = 0;
            end
        end
    end

    task automatic drive(input bit v, input logic [7:0] id, input bit rdy, input bit done);
        cmd_valid_i   = v;
        cmd_i.cmd_id  = id;
        cmd_i.opcode  = 4'($urandom);
        cmd_i.addr    = $urandom;
        eng_ready_i   = rdy;
        eng_done_i    = done;
    endtask

    task automatic test_reset();
        rst_ni = 0;
        drive(0, 8'h00, 0, 0);
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({cmd_resp_valid_o, eng_valid_o, busy_o, err_o, eng_cmd_o, cmd_resp_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rv=%0b ev=%0b busy=%0b err=%0b cmd=%h resp=%h, want all 0",
                     cmd_resp_valid_o, eng_valid_o, busy_o, err_o, eng_cmd_o, cmd_resp_o);
        end
        rst_ni = 1;
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL reset_ready: got %0b want 1", cmd_ready_o);
        end
        @(negedge clk_i);
    endtask

    task automatic test_single();
        drive(1, 8'h15, 1, 0);
        @(negedge clk_i);
        n_checks++;
        if (eng_valid_o !== 1'b1 || eng_cmd_o.cmd_id !== 8'h15 || eng_cmd_o !== m_eng_cmd) begin
            n_fail++; $display("FAIL single_issue: got v=%0b cmd=%h want v=1 cmd=%h", eng_valid_o, eng_cmd_o, m_eng_cmd);
        end
        drive(0, 8'h00, 1, 0);
        @(negedge clk_i);
        n_checks++;
        if (eng_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL single_handoff: got v=%0b busy=%0b want v=0 busy=1", eng_valid_o, busy_o);
        end
        @(negedge clk_i);
        drive(0, 8'h00, 1, 1);
        @(negedge clk_i);
        n_checks++;
        if (cmd_resp_valid_o !== 1'b1 || cmd_resp_o.cmd_id !== 8'h15 || cmd_resp_o.status !== 2'b00 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL single_resp: got rv=%0b resp=%h busy=%0b want rv=1 id=15 busy=0",
                               cmd_resp_valid_o, cmd_resp_o, busy_o);
        end
        drive(0, 8'h00, 1, 0);
        @(negedge clk_i);
        n_checks++;
        if (cmd_resp_valid_o !== 1'b0 || cmd_resp_o.cmd_id !== 8'h15) begin
            n_fail++; $display("FAIL single_resp_hold: got rv=%0b id=%h want rv=0 id=15", cmd_resp_valid_o, cmd_resp_o.cmd_id);
        end
    endtask

    task automatic test_full_and_drain();
        for (int i = 1; i <= 5; i++) begin
            drive(1, 8'(i), 1, 0);
            #1;
            n_checks++;
            if (cmd_ready_o !== (i <= MAX)) begin
                n_fail++; $display("FAIL full_ready id=%0d: got %0b want %0b", i, cmd_ready_o, (i <= MAX));
            end
            @(negedge clk_i);
        end
        drive(1, 8'd5, 1, 1);
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL full_ready_on_done: got %0b want 0", cmd_ready_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (cmd_resp_valid_o !== 1'b1 || cmd_resp_o.cmd_id !== 8'd1) begin
            n_fail++; $display("FAIL full_resp: got rv=%0b id=%h want rv=1 id=01", cmd_resp_valid_o, cmd_resp_o.cmd_id);
        end
        drive(1, 8'd5, 1, 0);
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL full_slot_freed: got %0b want 1", cmd_ready_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (eng_valid_o !== 1'b1 || eng_cmd_o.cmd_id !== 8'd5 || cmd_resp_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL full_accept5: got ev=%0b id=%h rv=%0b want ev=1 id=05 rv=0",
                               eng_valid_o, eng_cmd_o.cmd_id, cmd_resp_valid_o);
        end
        for (int k = 0; k < 4; k++) begin
            drive(0, 8'h00, 1, 1);
            @(negedge clk_i);
            n_checks++;
            if (cmd_resp_valid_o !== 1'b1 || cmd_resp_o.cmd_id !== 8'(k + 2)) begin
                n_fail++; $display("FAIL drain_resp%0d: got rv=%0b id=%h want rv=1 id=%h",
                                   k, cmd_resp_valid_o, cmd_resp_o.cmd_id, 8'(k + 2));
            end
        end
        drive(0, 8'h00, 1, 0);
        @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0 || cmd_resp_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL drain_idle: got busy=%0b rv=%0b want 0 0", busy_o, cmd_resp_valid_o);
        end
    endtask

    task automatic test_stall();
        cmd_req_t exp_cmd;
        drive(1, 8'h20, 0, 0);
        exp_cmd = cmd_i;
        @(negedge clk_i);
        for (int c = 0; c < 10; c++) begin
            drive(1, 8'h21, 0, 0);
            #1;
            n_checks++;
            if (cmd_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL stall_ready c=%0d: got %0b want 0", c, cmd_ready_o);
            end
            @(negedge clk_i);
            n_checks++;
            if (eng_valid_o !== 1'b1 || eng_cmd_o !== exp_cmd) begin
                n_fail++; $display("FAIL stall_hold c=%0d: got v=%0b cmd=%h want v=1 cmd=%h", c, eng_valid_o, eng_cmd_o, exp_cmd);
            end
        end
        drive(1, 8'h21, 1, 0);
        exp_cmd = cmd_i;
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_ready: got %0b want 1", cmd_ready_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (eng_valid_o !== 1'b1 || eng_cmd_o !== exp_cmd) begin
            n_fail++; $display("FAIL stall_reload: got v=%0b cmd=%h want v=1 cmd=%h", eng_valid_o, eng_cmd_o, exp_cmd);
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 8'h00, 1, 1);
            @(negedge clk_i);
            n_checks++;
            if (cmd_resp_valid_o !== 1'b1 || cmd_resp_o.cmd_id !== 8'(8'h20 + k)) begin
                n_fail++; $display("FAIL stall_resp%0d: got rv=%0b id=%h want rv=1 id=%h",
                                   k, cmd_resp_valid_o, cmd_resp_o.cmd_id, 8'(8'h20 + k));
            end
        end
        n_checks++;
        if (busy_o !== 1'b0 || eng_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_final: got busy=%0b ev=%0b want 0 0", busy_o, eng_valid_o);
        end
    endtask

    task automatic test_same_cycle();
        drive(1, 8'd3, 1, 0);
        @(negedge clk_i);
        drive(1, 8'd7, 1, 1);
        #1;
        n_checks++;
        if (cmd_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL same_ready: got %0b want 1", cmd_ready_o);
        end
        @(negedge clk_i);
        n_checks++;
        if (cmd_resp_valid_o !== 1'b1 || cmd_resp_o.cmd_id !== 8'd3 || busy_o !== 1'b1 || eng_cmd_o.cmd_id !== 8'd7) begin
            n_fail++; $display("FAIL same_resp: got rv=%0b id=%h busy=%0b eng_id=%h want 1 03 1 07",
                               cmd_resp_valid_o, cmd_resp_o.cmd_id, busy_o, eng_cmd_o.cmd_id);
        end
        drive(0, 8'h00, 1, 1);
        @(negedge clk_i);
        n_checks++;
        if (cmd_resp_valid_o !== 1'b1 || cmd_resp_o.cmd_id !== 8'd7 || busy_o !== 1'b0) begin
            n_fail++; $display("FAIL same_next: got rv=%0b id=%h busy=%0b want 1 07 0", cmd_resp_valid_o, cmd_resp_o.cmd_id, busy_o);
        end
    endtask

    task automatic test_err_and_reset();
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fail++; $display("FAIL err_initial: got %0b want 0", err_o);
        end
        drive(0, 8'h00, 1, 1);
        @(negedge clk_i);
        n_checks++;
        if (cmd_resp_valid_o !== 1'b0 || err_o !== 1'b1) begin
            n_fail++; $display("FAIL err_stray: got rv=%0b err=%0b want 0 1", cmd_resp_valid_o, err_o);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 8'(8'h31 + i), 1, 0);
            @(negedge clk_i);
        end
        n_checks++;
        if (err_o !== 1'b1 || busy_o !== 1'b1) begin
            n_fail++; $display("FAIL err_sticky: got err=%0b busy=%0b want 1 1", err_o, busy_o);
        end
        drive(0, 8'h00, 1, 0);
        #2 rst_ni = 0;
        #1;
        n_checks++;
        if ({cmd_resp_valid_o, eng_valid_o, busy_o, err_o, eng_cmd_o, cmd_resp_o} !== '0) begin
            n_fail++; $display("FAIL midreset: got rv=%0b ev=%0b busy=%0b err=%0b want all 0",
                               cmd_resp_valid_o, eng_valid_o, busy_o, err_o);
        end
        @(negedge clk_i);
        rst_ni = 1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 8'h00, 1, 1);
            @(negedge clk_i);
            n_checks++;
            if (cmd_resp_valid_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL postreset_noresp%0d: got rv=%0b busy=%0b want 0 0", i, cmd_resp_valid_o, busy_o);
            end
        end
        drive(0, 8'h00, 1, 0);
        @(negedge clk_i);
    endtask

    task automatic test_random();
        cmd_resp_t exp_resp;
        rst_ni = 0;
        @(negedge clk_i);
        rst_ni = 1;
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            #1;
            n_checks++;
            if (cmd_ready_o !== exp_ready()) begin
                n_fail++; $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, cmd_ready_o, exp_ready());
            end
            @(negedge clk_i);
            exp_resp        = '0;
            exp_resp.cmd_id = m_resp_id;
            n_checks++;
            if (cmd_resp_valid_o !== m_resp_valid || cmd_resp_o !== exp_resp) begin
                n_fail++; $display("FAIL rnd_resp c=%0d: got rv=%0b resp=%h want rv=%0b resp=%h",
                                   c, cmd_resp_valid_o, cmd_resp_o, m_resp_valid, exp_resp);
            end
            n_checks++;
            if (eng_valid_o !== m_eng_valid || eng_cmd_o !== m_eng_cmd) begin
                n_fail++; $display("FAIL rnd_eng c=%0d: got v=%0b cmd=%h want v=%0b cmd=%h",
                                   c, eng_valid_o, eng_cmd_o, m_eng_valid, m_eng_cmd);
            end
            n_checks++;
            if (busy_o !== (m_q.size() != 0) || err_o !== m_err) begin
                n_fail++; $display("FAIL rnd_status c=%0d: got busy=%0b err=%0b want busy=%0b err=%0b",
                                   c, busy_o, err_o, (m_q.size() != 0), m_err);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_and_drain();
        test_stall();
        test_same_cycle();
        test_err_and_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
